// File: rtl/s_axis_video_rx.sv
// AXI4-Stream video slave: converts a tuser/tlast framed pixel stream into the
// internal pixel bus with (x, y) coordinates, framing checks and resync.
module s_axis_video_rx #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [12:0]           IMG_WIDTH,
  input  logic [12:0]           IMG_HEIGHT,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_pixel_valid,
  output logic                  o_start_of_frame,
  output logic                  o_end_of_line,
  output logic                  o_end_of_frame,
  output logic [12:0]           o_x,
  output logic [12:0]           o_y,
  output logic                  o_err_sof,
  output logic                  o_err_early_eol,
  output logic                  o_err_late_eol,
  output logic [15:0]           o_frame_count,
  output logic [15:0]           o_drop_count
);

  localparam int unsigned CW = 13;
  localparam int unsigned NW = 16;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         x_cnt, y_cnt, w_lat, h_lat;
  logic [CW-1:0]         x_n, y_n, w_n, h_n;
  logic [DATA_WIDTH-1:0] pixel_n;
  logic [CW-1:0]         ox_n, oy_n;
  logic                  valid_n, sof_n, eol_n, eof_n;
  logic                  err_sof_n, err_early_n, err_late_n;
  logic [NW-1:0]         fc_n, dc_n;
  logic                  accept;
  logic                  last_col;

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign last_col = (x_cnt == w_lat - CW'(1));

  // Next-state, counter and output computation for one accepted beat.
  always_comb begin
    state_n     = state;
    x_n         = x_cnt;
    y_n         = y_cnt;
    w_n         = w_lat;
    h_n         = h_lat;
    pixel_n     = o_pixel;
    ox_n        = o_x;
    oy_n        = o_y;
    valid_n     = 1'b0;
    sof_n       = 1'b0;
    eol_n       = 1'b0;
    eof_n       = 1'b0;
    err_sof_n   = 1'b0;
    err_early_n = 1'b0;
    err_late_n  = 1'b0;
    fc_n        = o_frame_count;
    dc_n        = o_drop_count;

    if (accept) begin
      if (s_axis_tuser) begin
        // Start of frame: from idle, or a resync when seen mid-frame.
        err_sof_n = (state == ACTIVE);
        state_n   = ACTIVE;
        w_n       = IMG_WIDTH;
        h_n       = IMG_HEIGHT;
        pixel_n   = s_axis_tdata;
        ox_n      = '0;
        oy_n      = '0;
        valid_n   = 1'b1;
        sof_n     = 1'b1;
        if (s_axis_tlast) begin
          err_early_n = 1'b1;
          eol_n       = 1'b1;
          x_n         = '0;
          y_n         = CW'(1);
        end else begin
          x_n = CW'(1);
          y_n = '0;
        end
      end else if (state == WAIT_SOF) begin
        // Out-of-frame beat: discard and count, saturating.
        if (o_drop_count != {NW{1'b1}}) dc_n = o_drop_count + NW'(1);
      end else begin
        pixel_n = s_axis_tdata;
        ox_n    = x_cnt;
        oy_n    = y_cnt;
        valid_n = 1'b1;
        if (s_axis_tlast || last_col) begin
          eol_n       = 1'b1;
          err_early_n = s_axis_tlast && (x_cnt < w_lat - CW'(1));
          err_late_n  = !s_axis_tlast && last_col;
          x_n         = '0;
          y_n         = y_cnt + CW'(1);
          if (y_cnt == h_lat - CW'(1)) begin
            eof_n   = 1'b1;
            fc_n    = o_frame_count + NW'(1);
            state_n = WAIT_SOF;
          end
        end else begin
          x_n = x_cnt + CW'(1);
        end
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state            <= WAIT_SOF;
      x_cnt            <= '0;
      y_cnt            <= '0;
      w_lat            <= '0;
      h_lat            <= '0;
      s_axis_tready    <= 1'b0;
      o_pixel          <= '0;
      o_pixel_valid    <= 1'b0;
      o_start_of_frame <= 1'b0;
      o_end_of_line    <= 1'b0;
      o_end_of_frame   <= 1'b0;
      o_x              <= '0;
      o_y              <= '0;
      o_err_sof        <= 1'b0;
      o_err_early_eol  <= 1'b0;
      o_err_late_eol   <= 1'b0;
      o_frame_count    <= '0;
      o_drop_count     <= '0;
    end else begin
      state            <= state_n;
      x_cnt            <= x_n;
      y_cnt            <= y_n;
      w_lat            <= w_n;
      h_lat            <= h_n;
      s_axis_tready    <= i_enable;
      o_pixel          <= pixel_n;
      o_pixel_valid    <= valid_n;
      o_start_of_frame <= sof_n;
      o_end_of_line    <= eol_n;
      o_end_of_frame   <= eof_n;
      o_x              <= ox_n;
      o_y              <= oy_n;
      o_err_sof        <= err_sof_n;
      o_err_early_eol  <= err_early_n;
      o_err_late_eol   <= err_late_n;
      o_frame_count    <= fc_n;
      o_drop_count     <= dc_n;
    end
  end

endmodule

// File: tb/tb_s_axis_video_rx.sv
// Self-checking bench for s_axis_video_rx: directed framing cases plus a
// randomized valid/enable run with a mid-frame reset, against a beat-level model.
module tb_s_axis_video_rx;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [12:0]   img_w, img_h;
  logic          enable;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tuser, tlast;
  logic [DW-1:0] pixel;
  logic          pixel_valid, sof, eol, eof;
  logic [12:0]   ox, oy;
  logic          err_sof, err_early, err_late;
  logic [15:0]   frame_count, drop_count;

  int tests = 0;
  int fails = 0;

  // Reference model state (plain integers, one update per accepted beat).
  bit     m_active;
  int     m_x, m_y, m_w, m_h, m_fc, m_dc;
  logic [DW-1:0] e_pix;
  int     e_x, e_y;
  bit     e_valid, e_sof, e_eol, e_eof, e_esof, e_early, e_late, e_ready;

  s_axis_video_rx #(.DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_aresetn(rst_n), .IMG_WIDTH(img_w), .IMG_HEIGHT(img_h),
    .i_enable(enable), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .o_pixel(pixel), .o_pixel_valid(pixel_valid), .o_start_of_frame(sof),
    .o_end_of_line(eol), .o_end_of_frame(eof), .o_x(ox), .o_y(oy),
    .o_err_sof(err_sof), .o_err_early_eol(err_early), .o_err_late_eol(err_late),
    .o_frame_count(frame_count), .o_drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_x = 0; m_y = 0; m_w = 0; m_h = 0; m_fc = 0; m_dc = 0;
    e_pix = '0; e_x = 0; e_y = 0; e_ready = 0;
    {e_valid, e_sof, e_eol, e_eof, e_esof, e_early, e_late} = '0;
  endtask

  // Behaviour of one beat as seen from the outside of the block.
  task automatic model_beat(input bit acc, input logic [DW-1:0] d, input bit u, input bit l);
    {e_valid, e_sof, e_eol, e_eof, e_esof, e_early, e_late} = '0;
    if (!acc) return;
    if (u) begin
      e_esof = m_active;
      m_active = 1; m_w = int'(img_w); m_h = int'(img_h);
      e_valid = 1; e_sof = 1; e_pix = d; e_x = 0; e_y = 0;
      if (l) begin e_early = 1; e_eol = 1; m_x = 0; m_y = 1; end
      else   begin m_x = 1; m_y = 0; end
    end else if (!m_active) begin
      if (m_dc < 65535) m_dc++;
    end else begin
      e_valid = 1; e_pix = d; e_x = m_x; e_y = m_y;
      if (l || m_x == m_w - 1) begin
        e_eol = 1;
        e_early = l && (m_x < m_w - 1);
        e_late = !l && (m_x == m_w - 1);
        if (m_y == m_h - 1) begin
          e_eof = 1; m_fc = (m_fc + 1) % 65536; m_active = 0;
        end
        m_x = 0; m_y++;
      end else m_x++;
    end
  endtask

  task automatic compare_all();
    chk("tready", 32'(tready), 32'(e_ready));
    chk("pixel", pixel, e_pix);
    chk("x", 32'(ox), 32'(e_x));
    chk("y", 32'(oy), 32'(e_y));
    chk("strobes", 32'({pixel_valid, sof, eol, eof}), 32'({e_valid, e_sof, e_eol, e_eof}));
    chk("errors", 32'({err_sof, err_early, err_late}), 32'({e_esof, e_early, e_late}));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
  endtask

  // One clock: drive at negedge, observe at the following negedge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit u, input bit l,
                      input bit en, output bit acc);
    tvalid = v; tdata = d; tuser = u; tlast = l; enable = en;
    acc = v && (tready === 1'b1);
    @(posedge clk);
    @(negedge clk);
    model_beat(acc, d, u, l);
    e_ready = en;
    compare_all();
  endtask

  // Present a beat with enable high until accepted (bounded).
  task automatic beat(input logic [DW-1:0] d, input bit u, input bit l);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, d, u, l, 1'b1, acc);
      n++;
    end while (!acc && n < 20);
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL beat_accept_timeout data=%0h never accepted within 20 cycles", d);
    end
    tvalid = 1'b0;
  endtask

  task automatic clean_frame(input int base);
    for (int k = 0; k < 12; k++) beat(DW'(base + k), k == 0, (k % 4) == 3);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    tvalid = 1'b0;
    #1;
    model_reset();
    chk("reset_outputs", 32'({pixel_valid, sof, eol, eof, err_sof, err_early, err_late, tready}), 32'(0));
    chk("reset_xy", 32'({ox, oy}), 32'(0));
    chk("reset_pixel", pixel, '0);
    chk("reset_counts", {frame_count, drop_count}, 32'(0));
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int fc0, k, f, cyc, rst_k, frame_beats;
    bit rst_done;
    logic [DW-1:0] d;

    rst_n = 1'b0; enable = 1'b1; tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0;
    img_w = 13'd4; img_h = 13'd3;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Clean 4x3 frame, data 0..11.
    clean_frame(0);
    chk("clean_eof_data", pixel, 32'd11);
    chk("clean_frame_count", 32'(frame_count), 32'd1);

    // Five out-of-frame beats are dropped, then a clean frame.
    for (int i = 0; i < 5; i++) beat(DW'(100 + i), 1'b0, 1'b0);
    chk("drop_count_5", 32'(drop_count), 32'd5);
    beat(32'd0, 1'b1, 1'b0);
    chk("first_after_drop", 32'({sof, pixel_valid, ox, oy}), 32'({2'b11, 26'd0}));
    for (int k2 = 1; k2 < 12; k2++) beat(DW'(k2), 1'b0, (k2 % 4) == 3);

    // Early tlast on the third pixel of line 0.
    fc0 = int'(frame_count);
    beat(32'd200, 1'b1, 1'b0);
    beat(32'd201, 1'b0, 1'b0);
    beat(32'd202, 1'b0, 1'b1);
    chk("early_eol_xy", 32'({err_early, eol, ox, oy}), 32'({2'b11, 13'd2, 13'd0}));
    beat(32'd203, 1'b0, 1'b0);
    chk("after_early_xy", 32'({ox, oy}), 32'({13'd0, 13'd1}));
    for (int k2 = 1; k2 < 8; k2++) beat(DW'(203 + k2), 1'b0, (k2 % 4) == 3);
    chk("early_frame_done", 32'(frame_count), 32'(fc0 + 1));

    // Missing tlast on the fourth pixel of line 1.
    for (int k2 = 0; k2 < 12; k2++) begin
      beat(DW'(300 + k2), k2 == 0, (k2 % 4) == 3 && k2 != 7);
      if (k2 == 7) chk("late_eol_xy", 32'({err_late, eol, ox, oy}), 32'({2'b11, 13'd3, 13'd1}));
      if (k2 == 8) chk("after_late_xy", 32'({ox, oy}), 32'({13'd0, 13'd2}));
    end

    // tuser on beat 6 restarts the frame.
    fc0 = int'(frame_count);
    for (int k2 = 0; k2 < 5; k2++) beat(DW'(400 + k2), k2 == 0, (k2 % 4) == 3);
    beat(32'd500, 1'b1, 1'b0);
    chk("resync_sof", 32'({err_sof, sof, ox, oy}), 32'({2'b11, 26'd0}));
    for (int k2 = 1; k2 < 12; k2++) beat(DW'(500 + k2), 1'b0, (k2 % 4) == 3);
    chk("resync_frame_count", 32'(frame_count), 32'(fc0 + 1));

    // Random valid/enable over three 5x4 frames with a reset in frame 2.
    img_w = 13'd5; img_h = 13'd4;
    frame_beats = 20;
    rst_k = 7;
    rst_done = 0;
    cyc = 0;
    d = $urandom;
    for (f = 0; f < 3; f++) begin
      k = 0;
      while (k < frame_beats && cyc < 3000) begin
        if (f == 1 && k == rst_k && !rst_done) begin
          reset_pulse();
          rst_done = 1;
        end
        step(($urandom % 4) != 0, d, k == 0, (k % 5) == 4, ($urandom % 5) != 0, acc);
        cyc++;
        if (acc) begin k++; d = $urandom; end
      end
      if (f == 1) chk("post_reset_drops", 32'(drop_count), 32'(frame_beats - rst_k));
    end
    tests++;
    if (cyc >= 3000) begin
      fails++;
      $display("FAIL random_run_budget cycles=%0d limit=3000", cyc);
    end
    tvalid = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("final_frame_count", 32'(frame_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s_axis_video_rx.md
# s_axis_video_rx

AXI4-Stream video slave that accepts a frame-framed pixel stream (tuser = start of frame, tlast = end of line) and converts it to the internal pixel bus: registered pixel, pixel-valid, start-of-frame, end-of-line and end-of-frame strobes, plus (x, y) coordinates. It sits at the input of the gradient pipeline, ahead of the line buffers and kernel window. Upstream is either an AXIS video source or the pipeline's own AXIS master output in loop-back.

It checks framing against the programmed geometry, flags errors and resynchronises, so downstream kernels always see well-formed coordinates.

## Interface
- DATA_WIDTH, 32, width of tdata and pixel bus
- i_clk  input  1  single clock; all logic rising-edge
- i_aresetn  input  1  reset, asynchronous, active-low
- IMG_WIDTH  input  13  pixels per line; valid range 2..4095
- IMG_HEIGHT  input  13  lines per frame; valid range 2..4095
- i_enable  input  1  allows acceptance of beats
- s_axis_tdata  input  DATA_WIDTH  pixel data
- s_axis_tvalid  input  1  beat valid
- s_axis_tready  output  1  beat accept (registered)
- s_axis_tuser  input  1  start of frame, on first pixel
- s_axis_tlast  input  1  end of line, on last pixel of each line
- o_pixel  output  DATA_WIDTH  accepted pixel
- o_pixel_valid  output  1  one-cycle strobe per accepted in-frame pixel
- o_start_of_frame  output  1  with pixel (0,0)
- o_end_of_line  output  1  with last pixel of a line
- o_end_of_frame  output  1  with pixel (W-1,H-1)
- o_x, o_y  output  13 each  coordinates of o_pixel
- o_err_sof  output  1  pulse: tuser inside a frame
- o_err_early_eol  output  1  pulse: tlast with x < W-1
- o_err_late_eol  output  1  pulse: x == W-1 without tlast
- o_frame_count  output  16  completed frames, wraps 0xFFFF->0
- o_drop_count  output  16  beats discarded in WAIT_SOF, saturates at 0xFFFF

## Operation
- Accept = s_axis_tvalid && s_axis_tready. Nothing else changes state or counters.
- s_axis_tready is a register equal to i_enable, delayed one cycle. It is 0 in reset.
- W and H are latched from IMG_WIDTH/IMG_HEIGHT on each SOF accept. Mid-frame changes are ignored.
- Internal x/y counters are 13-bit.
- State WAIT_SOF (reset state):
  - Accept with tuser=0: discard the beat, no pixel output, o_drop_count += 1 (saturating).
  - Accept with tuser=1: output the pixel at (0,0) with o_start_of_frame=1. Set x=1, y=0, go to ACTIVE.
  - If tlast=1 on this SOF beat, o_err_early_eol=1, then x=0, y=1.
- State ACTIVE, for each accept:
  - tuser=1: o_err_sof=1. Treat the beat exactly as a WAIT_SOF SOF beat (restart at (0,0), relatch W/H). o_frame_count is not incremented.
  - Otherwise output the pixel at the current (x,y).
    - tlast=1 and x<W-1: o_err_early_eol=1, o_end_of_line=1, then x=0, y+=1.
    - x==W-1 and tlast=0: o_err_late_eol=1, o_end_of_line=1, then x=0, y+=1.
    - x==W-1 and tlast=1: normal end of line, o_end_of_line=1, then x=0, y+=1.
  - End of frame: line end at y==H-1 (normal or error). Assert o_end_of_frame=1, o_frame_count += 1, return to WAIT_SOF.
  - An early EOL on the last line also ends the frame.
- Error pulses may coincide with each other and with the pixel strobes. They do not block output.
- i_enable=0 mid-frame only stalls acceptance. State and counters hold.

## Timing
- Every output is registered. Output strobes and o_pixel/o_x/o_y are updated in the cycle after the accepting edge, so latency is 1 clock.
- Strobes are high for exactly one cycle per accept. o_pixel, o_x and o_y hold their values between accepts.
- Throughput: one beat per clock while tvalid and tready are both high.
- Reset (asynchronous assertion at any time, including mid-frame):
  - All outputs 0, counters 0, state WAIT_SOF.
  - s_axis_tready rises on the first clock edge after deassertion on which i_enable=1.
- Backpressure: when tready=0, upstream holds its beat. The block samples nothing.

## Test plan
- W=4, H=3, one clean frame of 12 beats, data 0..11, tvalid continuous:
  - 12 pixel strobes with (x,y) raster order.
  - SOF with data 0; EOL with data 3, 7, 11; EOF with data 11.
  - o_frame_count=1, no errors.
- 5 beats with tuser=0, then a clean 4x3 frame: o_drop_count=5, first output is pixel 0 at (0,0) with SOF.
- W=4, H=3, tlast on the 3rd beat of line 0: o_err_early_eol on that pixel at (2,0), next pixel at (0,1). The frame ends after lines 1 and 2, o_frame_count=1.
- W=4, tlast missing on the 4th beat of line 1: o_err_late_eol and o_end_of_line at (3,1), next pixel at (0,2).
- tuser asserted on beat 6 of a 4x3 frame: o_err_sof with SOF at (0,0). A further 12 beats complete the frame, o_frame_count=1.
- Random tvalid and i_enable toggling over 3 frames; async reset pulse mid-frame 2:
  - All outputs 0 during reset.
  - Beats before the next tuser are dropped.
  - Frame 3 completes normally.
